// File: rtl/bus_req_arbiter.sv
// Round-robin arbiter that queues one single-beat request per requester and
// drives it onto a shared bus. Each transaction ends with an ack or a timeout.
module bus_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
)(
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*DW-1:0]   data_i,
    output logic [NREQ-1:0]      ack_o,
    output logic [NREQ-1:0]      err_o,
    output logic                 overrun_o,
    output logic                 bus_req,
    output logic [DW-1:0]        bus_data,
    input  logic                 bus_ack,
    output logic                 spurious_ack_o,
    output logic                 busy
);
    localparam int GW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                    r_state;
    logic [GW-1:0]             r_grant;
    logic [GW-1:0]             r_last;
    logic [7:0]                r_cnt;
    logic [NREQ-1:0]           r_pending;
    logic [NREQ-1:0][DW-1:0]   r_data;

    logic [GW-1:0]             w_next;
    logic [GW-1:0]             w_idx;
    logic                      w_any;
    logic                      w_tmo;
    logic                      w_done;
    logic [NREQ-1:0]           w_clr;
    logic [NREQ-1:0]           w_ovr;

    // The wait counter holds completed WAIT cycles, so the last one is TIMEOUT-1.
    assign w_tmo  = (r_cnt == 8'(TIMEOUT - 1));
    assign w_done = (r_state == WAIT) && (bus_ack || w_tmo);

    for (genvar k = 0; k < NREQ; k++) begin : g_slot
        assign w_clr[k] = w_done && (r_grant == GW'(k));
        assign w_ovr[k] = req_i[k] && r_pending[k] && !w_clr[k];
    end

    // Round-robin pick: scan from farthest to nearest after last_grant so the nearest pending wins.
    always_comb begin : p_rr
        int t;
        t      = 0;
        w_any  = 1'b0;
        w_next = r_last;
        w_idx  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            t = int'(r_last) + i;
            if (t >= NREQ) t = t - NREQ;
            w_idx = GW'(t);
            if (r_pending[w_idx]) begin
                w_any  = 1'b1;
                w_next = w_idx;
            end
        end
    end

    // Per-requester slots: a new request is taken when the slot is free or being released this cycle.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_pending <= '0;
            r_data    <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                if (req_i[k] && (!r_pending[k] || w_clr[k])) begin
                    r_pending[k] <= 1'b1;
                    r_data[k]    <= data_i[k*DW +: DW];
                end else if (w_clr[k]) begin
                    r_pending[k] <= 1'b0;
                end
            end
        end
    end

    // Transaction FSM with all bus-side and completion outputs registered.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state        <= IDLE;
            r_grant        <= '0;
            r_last         <= GW'(NREQ - 1);
            r_cnt          <= '0;
            ack_o          <= '0;
            err_o          <= '0;
            overrun_o      <= 1'b0;
            bus_req        <= 1'b0;
            bus_data       <= '0;
            spurious_ack_o <= 1'b0;
            busy           <= 1'b0;
        end else begin
            ack_o          <= '0;
            err_o          <= '0;
            bus_req        <= 1'b0;
            spurious_ack_o <= 1'b0;
            overrun_o      <= |w_ovr;
            case (r_state)
                IDLE: begin
                    spurious_ack_o <= bus_ack;
                    if (w_any) begin
                        r_grant  <= w_next;
                        bus_data <= r_data[w_next];
                        busy     <= 1'b1;
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    spurious_ack_o <= bus_ack;
                    bus_req        <= 1'b1;
                    r_cnt          <= '0;
                    r_state        <= WAIT;
                end
                WAIT: begin
                    if (bus_ack) begin
                        ack_o[r_grant] <= 1'b1;
                    end else if (w_tmo) begin
                        err_o[r_grant] <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                    if (w_done) begin
                        r_last  <= r_grant;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_req_arbiter.sv
// Bench for bus_req_arbiter: directed scenarios plus random traffic, with a
// reference model predicting output events into per-kind scoreboard queues.
module tb_bus_req_arbiter;
    localparam int NREQ    = 4;
    localparam int DW      = 32;
    localparam int TIMEOUT = 15;

    logic                clk;
    logic                reset_l;
    logic [NREQ-1:0]     req_i;
    logic [NREQ*DW-1:0]  data_i;
    logic [NREQ-1:0]     ack_o;
    logic [NREQ-1:0]     err_o;
    logic                overrun_o;
    logic                bus_req;
    logic [DW-1:0]       bus_data;
    logic                bus_ack;
    logic                spurious_ack_o;
    logic                busy;

    bus_req_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_l(reset_l), .req_i(req_i), .data_i(data_i),
        .ack_o(ack_o), .err_o(err_o), .overrun_o(overrun_o),
        .bus_req(bus_req), .bus_data(bus_data), .bus_ack(bus_ack),
        .spurious_ack_o(spurious_ack_o), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              cyc;
        int              k;
        logic [DW-1:0]   d;
    } ev_t;

    ev_t q_bus[$], q_ack[$], q_err[$], q_ovr[$], q_spur[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    function automatic ev_t mk(input int c, input int k, input logic [DW-1:0] d);
        ev_t e;
        e.cyc = c; e.k = k; e.d = d;
        return e;
    endfunction

    // ---------------- reference model ----------------
    // Phases: 0 = idle, 1 = issuing, 2 = waiting for the target.
    bit            mpend[NREQ];
    logic [DW-1:0] mdata[NREQ];
    bit            pend0[NREQ];
    logic [DW-1:0] data0[NREQ];
    int            mlast, mg, mph, mwaited, ph0, j;
    logic [DW-1:0] mbus;
    bit            done, ovr;

    always @(posedge clk) begin
        cyc++;
        if (!reset_l) begin
            for (int k = 0; k < NREQ; k++) begin mpend[k] = 0; mdata[k] = '0; end
            mlast = NREQ - 1; mg = 0; mph = 0; mwaited = 0;
            q_bus.delete(); q_ack.delete(); q_err.delete(); q_ovr.delete(); q_spur.delete();
        end else begin
            ph0 = mph; pend0 = mpend; data0 = mdata; done = 0; ovr = 0;
            // target side: ack ends the wait; otherwise one more waited cycle
            if (ph0 == 2) begin
                if (bus_ack) begin
                    q_ack.push_back(mk(cyc, mg, '0)); done = 1;
                end else if (mwaited + 1 == TIMEOUT) begin
                    q_err.push_back(mk(cyc, mg, '0)); done = 1;
                end else begin
                    mwaited++;
                end
            end else if (bus_ack) begin
                q_spur.push_back(mk(cyc, 0, '0));
            end
            // release the finished slot first, then admit requests into free slots
            if (done) begin mpend[mg] = 0; mlast = mg; end
            for (int k = 0; k < NREQ; k++) begin
                if (req_i[k]) begin
                    if (!mpend[k]) begin mpend[k] = 1; mdata[k] = data_i[k*DW +: DW]; end
                    else ovr = 1;
                end
            end
            if (ovr) q_ovr.push_back(mk(cyc, 0, '0));
            case (ph0)
                0: begin
                    for (int i = 1; i <= NREQ; i++) begin
                        j = (mlast + i) % NREQ;
                        if (pend0[j] && mph == 0) begin
                            mg = j; mbus = data0[j]; mph = 1;
                        end
                    end
                end
                1: begin
                    q_bus.push_back(mk(cyc, mg, mbus));
                    mwaited = 0; mph = 2;
                end
                default: if (done) mph = 0;
            endcase
        end
    end

    // ---------------- monitor ----------------
    ev_t e;
    always @(negedge clk) begin
        if (reset_l) begin
            chk("busy", busy, (mph != 0));
            if (bus_req) begin
                if (q_bus.size() == 0) chk("bus_req_unexpected", 1, 0);
                else begin
                    e = q_bus.pop_front();
                    chk("bus_req_cycle", cyc, e.cyc);
                    chk("bus_data", bus_data, e.d);
                end
            end
            if (ack_o != 0) begin
                if (q_ack.size() == 0) chk("ack_unexpected", ack_o, 0);
                else begin
                    e = q_ack.pop_front();
                    chk("ack_cycle", cyc, e.cyc);
                    chk("ack_vec", ack_o, 64'(1) << e.k);
                end
            end
            if (err_o != 0) begin
                if (q_err.size() == 0) chk("err_unexpected", err_o, 0);
                else begin
                    e = q_err.pop_front();
                    chk("err_cycle", cyc, e.cyc);
                    chk("err_vec", err_o, 64'(1) << e.k);
                end
            end
            if (ack_o != 0 && err_o != 0) chk("ack_err_exclusive", {ack_o, err_o}, {ack_o, 4'b0});
            if (overrun_o) begin
                if (q_ovr.size() == 0) chk("overrun_unexpected", 1, 0);
                else begin e = q_ovr.pop_front(); chk("overrun_cycle", cyc, e.cyc); end
            end
            if (spurious_ack_o) begin
                if (q_spur.size() == 0) chk("spurious_unexpected", 1, 0);
                else begin e = q_spur.pop_front(); chk("spurious_cycle", cyc, e.cyc); end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [NREQ-1:0] r, input logic a);
        req_i = r; bus_ack = a;
        @(negedge clk);
    endtask

    task automatic wait_busreq(input int maxc);
        int n;
        n = 0;
        while (!bus_req && n < maxc) begin step('0, 1'b0); n++; end
        chk("bus_req_seen", bus_req, 1);
    endtask

    task automatic grant_ack(input int k, input string nm);
        wait_busreq(12);
        step('0, 1'b1);
        chk(nm, ack_o, 64'(1) << k);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {ack_o, err_o, overrun_o, bus_req, bus_data, spurious_ack_o, busy}, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        logic [NREQ-1:0] r, acc;
        reset_l = 1'b0; req_i = '0; bus_ack = 1'b0; data_i = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset_outputs");
        reset_l = 1'b1;
        step('0, 1'b0);
        chk_all_zero("post_reset_idle");

        // contention: requester 0 wins first after reset, then 1,2,3
        for (int k = 0; k < NREQ; k++) data_i[k*DW +: DW] = 32'hA000_0000 + k;
        step(4'b1111, 1'b0);
        for (int k = 0; k < NREQ; k++) grant_ack(k, "contention_order");
        step(4'b0011, 1'b0);
        grant_ack(0, "round2_first");
        grant_ack(1, "round2_second");
        step(4'b0101, 1'b0);
        grant_ack(2, "rr_after_last1");
        grant_ack(0, "rr_wrap");

        // single request, ack two cycles after bus_req
        data_i = '0; data_i[1*DW +: DW] = 32'hfeed;
        step(4'b0010, 1'b0);
        wait_busreq(10);
        chk("single_bus_data", bus_data, 32'hfeed);
        step('0, 1'b0); step('0, 1'b0); step('0, 1'b1);
        chk("single_ack", ack_o, 4'b0010);
        chk("single_busy_low", busy, 0);
        step('0, 1'b0);

        // timeout with no ack
        step(4'b0001, 1'b0);
        wait_busreq(10);
        n = 0;
        while (n < 40) begin step('0, 1'b0); n++; if (err_o != 0) break; end
        chk("timeout_cycles", n, TIMEOUT);
        chk("timeout_err", err_o, 4'b0001);
        chk("timeout_no_ack", ack_o, 0);

        // ack exactly on the last waiting cycle wins
        step(4'b0010, 1'b0);
        wait_busreq(10);
        repeat (TIMEOUT - 1) step('0, 1'b0);
        step('0, 1'b1);
        chk("late_ack", ack_o, 4'b0010);
        chk("late_ack_no_err", err_o, 0);
        step('0, 1'b0);

        // overrun keeps the first captured data
        data_i[0 +: DW] = 32'h1111_0000;
        step(4'b0001, 1'b0);
        data_i[0 +: DW] = 32'h2222_0000;
        step(4'b0001, 1'b0);
        chk("overrun_pulse", overrun_o, 1);
        wait_busreq(10);
        chk("overrun_data_kept", bus_data, 32'h1111_0000);
        step('0, 1'b1);
        chk("overrun_ack", ack_o, 4'b0001);
        step('0, 1'b0);

        // spurious ack in idle
        step('0, 1'b1);
        chk("spurious_pulse", spurious_ack_o, 1);
        chk("spurious_busy", busy, 0);
        step('0, 1'b0);
        chk("spurious_clear", spurious_ack_o, 0);
        chk("spurious_no_busreq", bus_req, 0);

        // reset during WAIT abandons the transaction
        data_i[3*DW +: DW] = 32'h3333_3333;
        step(4'b1000, 1'b0);
        wait_busreq(10);
        step('0, 1'b0);
        reset_l = 1'b0;
        #1;
        chk_all_zero("midwait_reset_outputs");
        step('0, 1'b0);
        reset_l = 1'b1;
        acc = '0;
        repeat (6) begin step('0, 1'b0); acc |= ack_o | err_o | {NREQ{bus_req}}; end
        chk("after_reset_quiet", acc, 0);
        step(4'b0100, 1'b0);
        grant_ack(2, "after_reset_ack");
        step('0, 1'b0);

        // random traffic against the model
        repeat (400) begin
            for (int k = 0; k < NREQ; k++) begin
                r[k] = ($urandom_range(0, 7) == 0);
                data_i[k*DW +: DW] = $urandom();
            end
            step(r, $urandom_range(0, 4) == 0);
        end
        repeat (150) step('0, $urandom_range(0, 2) == 0);
        repeat (3) step('0, 1'b0);
        chk("drain_busy", busy, 0);
        chk("q_bus_empty", q_bus.size(), 0);
        chk("q_ack_empty", q_ack.size(), 0);
        chk("q_err_empty", q_err.size(), 0);
        chk("q_ovr_empty", q_ovr.size(), 0);
        chk("q_spur_empty", q_spur.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
